// File: rtl/cpu_pkg.sv
// Shared opcodes, state encoding and instruction field positions
// for the alu_sequencer fetch/decode/execute controller.
package cpu_pkg;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_LDI = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_BRZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Arithmetic ops refresh zero; logic ops, MOV and LDI keep it.
  function automatic logic sets_zero(input logic [3:0] op);
    unique case (op)
      OP_ADD, OP_SUB, OP_MUL,
      OP_DIV, OP_INC, OP_DEC: sets_zero = 1'b1;
      OP_MOV, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_LDI: sets_zero = 1'b0;
      default:                sets_zero = 1'b0;
    endcase
  endfunction

  function automatic logic sets_carry(input logic [3:0] op);
    sets_carry = (op == OP_ADD) || (op == OP_SUB) ||
                 (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 4x8 register file: two asynchronous read ports,
// one synchronous write port, asynchronous clear.
module regfile4x8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving an external 8-bit ALU.
// ALU_SEQ_DIV_GUARD_EN: trap DIV by zero (R[rd]<=0xFF, sticky div_err).
module alu_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        alu_enable,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_operand_1,
  output logic [7:0]  alu_operand_2,
  input  logic [15:0] alu_result,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic [7:0]  hi_byte,
  output logic        div_err,
  output logic        halted
);

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        div_skip;
  logic        div_zero;

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic [7:0]  rd_data;
  logic [7:0]  rs_data;
  logic        wb_we;
  logic [7:0]  wb_data;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  assign imem_addr = pc;

`ifdef ALU_SEQ_DIV_GUARD_EN
  assign div_zero = (op == OP_DIV) && (rs_data == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  assign wb_we   = (state == S_WB);
  assign wb_data = div_skip ? 8'hFF : alu_result[7:0];

  regfile4x8 u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (rd),
    .wdata   (wb_data),
    .raddr_a (rd),
    .raddr_b (rs),
    .rdata_a (rd_data),
    .rdata_b (rs_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      pc            <= '0;
      ir            <= '0;
      div_skip      <= 1'b0;
      imem_req      <= 1'b0;
      alu_enable    <= 1'b0;
      alu_opcode    <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      hi_byte       <= '0;
      div_err       <= 1'b0;
      halted        <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      alu_enable <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          alu_opcode    <= op;
          alu_operand_1 <= (op == OP_LDI) ? imm : rd_data;
          alu_operand_2 <= rs_data;
          unique case (op)
            OP_OUT: begin
              out_data  <= rd_data;
              out_valid <= 1'b1;
              pc        <= pc + 8'd1;
              imem_req  <= 1'b1;
              state     <= S_FETCH;
            end
            OP_JMP: begin
              pc       <= imm;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_BRZ: begin
              pc       <= zero_flag ? imm : pc + 8'd1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              div_skip   <= div_zero;
              alu_enable <= !div_zero;
              state      <= S_EXEC;
            end
          endcase
        end
        S_EXEC: state <= S_WB;
        S_WB: begin
          if (sets_zero(op) && !div_skip)
            zero_flag <= (alu_result[7:0] == 8'h00);
          if (sets_carry(op))
            carry_flag <= alu_result[8];
          if (op == OP_MUL)
            hi_byte <= alu_result[15:8];
          if (div_skip)
            div_err <= 1'b1;
          div_skip <= 1'b0;
          pc       <= pc + 8'd1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU model, instruction memory,
// table vectors, corner sequences and random programs vs an ISA model.
module tb_alu_sequencer;

`ifdef ALU_SEQ_DIV_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        alu_enable;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_operand_1;
  logic [7:0]  alu_operand_2;
  logic [15:0] alu_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        zero_flag;
  logic        carry_flag;
  logic [7:0]  hi_byte;
  logic        div_err;
  logic        halted;

  alu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .alu_enable    (alu_enable),
    .alu_opcode    (alu_opcode),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_result    (alu_result),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .hi_byte       (hi_byte),
    .div_err       (div_err),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU; 16-bit result, carry/borrow lands in bit 8.
  function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = {8'h00, a};
    eb = {8'h00, b};
    case (op)
      4'h0:    return eb;
      4'h1:    return ea + eb;
      4'h2:    return ea - eb;
      4'h3:    return ea * eb;
      4'h4:    return (b == 0) ? 16'h0000 : ea / eb;
      4'h5:    return ea + 16'd1;
      4'h6:    return ea - 16'd1;
      4'h7:    return ea & eb;
      4'h8:    return ea | eb;
      4'h9:    return ea ^ eb;
      4'hA:    return {8'h00, ~a};
      4'hB:    return ea;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_operand_1, alu_operand_2);

  logic [15:0] mem [256];
  int ack_delay = 0;
  int wait_cnt = 0;
  int stab_err = 0;
  int ov_err = 0;
  int en_err = 0;
  int pulses = 0;
  logic [7:0] req_addr = '0;
  logic prev_ov = 1'b0;
  logic prev_en = 1'b0;
  logic [7:0] out_q [$];
  logic [7:0] fetch_q [$];

  int tests = 0;
  int failed = 0;

  // Memory responder and output monitor, both on the falling edge.
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (imem_req) begin
      if (wait_cnt > 0 && imem_addr != req_addr) stab_err++;
      if (wait_cnt == 0) req_addr = imem_addr;
      if (wait_cnt >= ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        fetch_q.push_back(imem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      if (wait_cnt > 0) stab_err++;
      wait_cnt = 0;
    end
    if (out_valid) begin
      out_q.push_back(out_data);
      if (prev_ov) ov_err++;
    end
    if (alu_enable) begin
      pulses++;
      if (prev_en) en_err++;
    end
    prev_ov = out_valid;
    prev_en = alu_enable;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] m_out [$];
  logic m_z, m_c, m_de;
  logic [7:0] m_hi;
  int m_pulses;

  // Instruction-level interpreter of the program in mem.
  task automatic model_run();
    logic [7:0] r [4];
    logic [7:0] pc;
    logic [15:0] w, res;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] a, b;
    m_out.delete();
    m_z = 0; m_c = 0; m_de = 0; m_hi = 0; m_pulses = 0;
    for (int i = 0; i < 4; i++) r[i] = 0;
    pc = 0;
    for (int s = 0; s < 500; s++) begin
      w = mem[pc];
      op = w[15:12]; rd = w[11:10]; rs = w[9:8];
      a = r[rd]; b = r[rs];
      if (op == 4'hF) break;
      if (op == 4'hC) begin
        m_out.push_back(a); pc = pc + 1;
      end else if (op == 4'hD) begin
        pc = w[7:0];
      end else if (op == 4'hE) begin
        pc = m_z ? w[7:0] : pc + 8'd1;
      end else if (op == 4'hB) begin
        r[rd] = w[7:0]; m_pulses++; pc = pc + 1;
      end else if (op == 4'h4 && GUARD && b == 0) begin
        r[rd] = 8'hFF; m_de = 1; pc = pc + 1;
      end else begin
        res = alu_fn(op, a, b);
        m_pulses++;
        r[rd] = res[7:0];
        if (op inside {[4'h1:4'h6]}) m_z = (res[7:0] == 0);
        if (op inside {4'h1, 4'h2, 4'h5, 4'h6}) m_c = res[8];
        if (op == 4'h3) m_hi = res[15:8];
        pc = pc + 1;
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic clear_mon();
    out_q.delete(); fetch_q.delete();
    pulses = 0; ov_err = 0; en_err = 0; stab_err = 0; wait_cnt = 0;
  endtask

  task automatic start_run(input int dly);
    reset = 1'b1;
    ack_delay = dly;
    @(posedge clk); #1;
    clear_mon();
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    int n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, " halt"}, halted, 1);
    @(negedge clk);
  endtask

  task automatic check_model(input string name);
    int n;
    model_run();
    check({name, " out count"}, out_q.size(), m_out.size());
    n = (out_q.size() < m_out.size()) ? out_q.size() : m_out.size();
    for (int i = 0; i < n; i++)
      check({name, " out value"}, out_q[i], m_out[i]);
    check({name, " zero"}, zero_flag, m_z);
    check({name, " carry"}, carry_flag, m_c);
    check({name, " hi_byte"}, hi_byte, m_hi);
    check({name, " div_err"}, div_err, m_de);
    check({name, " alu pulses"}, pulses, m_pulses);
    check({name, " strobe width"}, ov_err + en_err, 0);
    check({name, " req stable"}, stab_err, 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] e_out;
    bit         e_z;
    bit         e_c;
    logic [7:0] e_hi;
    bit         e_de;
    int         e_pulses;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];
  logic [15:0] progs [NV][8];

  initial begin
    logic [7:0] last;
    int seen, n, idx;

    progs[0] = '{16'hB005, 16'hB403, 16'h1100, 16'hC000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[0] = '{"add", 8'h08, 0, 0, 8'h00, 0, 3};
    progs[1] = '{16'hB0FF, 16'h5000, 16'hC000, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[1] = '{"inc wrap", 8'h00, 1, 1, 8'h00, 0, 2};
    progs[2] = '{16'hB810, 16'hBC20, 16'h3B00, 16'hC800,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[2] = '{"mul", 8'h00, 1, 0, 8'h02, 0, 3};
    progs[3] = '{16'hB007, 16'h4100, 16'hC000, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[3] = '{"div0", GUARD ? 8'hFF : 8'h00, !GUARD, 0, 8'h00,
              GUARD, GUARD ? 1 : 2};
    progs[4] = '{16'hB003, 16'hB405, 16'h2100, 16'hC000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[4] = '{"sub borrow", 8'hFE, 0, 1, 8'h00, 0, 3};
    progs[5] = '{16'hB480, 16'h1500, 16'hC400, 16'hF000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[5] = '{"add rd==rs", 8'h00, 1, 1, 8'h00, 0, 2};
    progs[6] = '{16'hB0FF, 16'h5000, 16'hA000, 16'hC000,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[6] = '{"not keeps flags", 8'hFF, 1, 1, 8'h00, 0, 3};
    progs[7] = '{16'hD004, 16'hB001, 16'hB002, 16'hF000,
                 16'hB009, 16'hC000, 16'hF000, 16'hF000};
    vt[7] = '{"jmp", 8'h09, 0, 0, 8'h00, 0, 1};
    progs[8] = '{16'hB000, 16'h6000, 16'h0C00, 16'hCC00,
                 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    vt[8] = '{"dec mov", 8'hFF, 0, 1, 8'h00, 0, 3};

    // Reset state
    fill_mem();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs",
          {imem_req, imem_addr, alu_enable, alu_opcode, alu_operand_1,
           alu_operand_2, out_data, out_valid, zero_flag, carry_flag},
          32'h0);
    check("reset flags", {hi_byte, div_err, halted}, 0);
    clear_mon();
    reset = 1'b0;
    @(posedge clk); #1;
    check("req after reset", {imem_req, imem_addr}, 9'h100);
    run_to_halt("empty");

    for (int v = 0; v < NV; v++) begin
      fill_mem();
      for (int i = 0; i < 8; i++) mem[i] = progs[v][i];
      start_run(v % 2);
      run_to_halt(vt[v].name);
      last = (out_q.size() > 0) ? out_q[out_q.size() - 1] : 8'hXX;
      check({vt[v].name, " out"}, last, vt[v].e_out);
      check({vt[v].name, " z"}, zero_flag, vt[v].e_z);
      check({vt[v].name, " c"}, carry_flag, vt[v].e_c);
      check({vt[v].name, " hi"}, hi_byte, vt[v].e_hi);
      check({vt[v].name, " de"}, div_err, vt[v].e_de);
      check({vt[v].name, " pulses"}, pulses, vt[v].e_pulses);
      check_model(vt[v].name);
    end

    // Halted stays quiet
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || !halted) n++;
    end
    check("halt holds", n, 0);

    // BRZ after INC wraps to zero
    fill_mem();
    mem[0] = 16'hB0FF; mem[1] = 16'h5000; mem[2] = 16'hE020;
    mem[8'h20] = 16'hF000;
    start_run(0);
    run_to_halt("brz");
    check("brz fetch count", fetch_q.size(), 4);
    if (fetch_q.size() > 3) check("brz target", fetch_q[3], 8'h20);
    check_model("brz");

    // Slow memory
    fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = progs[0][i];
    start_run(3);
    run_to_halt("slow ack");
    check("slow ack out", out_q.size() > 0 ? out_q[0] : 8'hXX, 8'h08);
    check_model("slow ack");

    // PC wrap 0xFF -> 0x00
    fill_mem();
    mem[0] = 16'hB401; mem[1] = 16'hE010; mem[2] = 16'hD0FF;
    mem[8'hFF] = 16'h6400; mem[8'h10] = 16'hC400; mem[8'h11] = 16'hF000;
    start_run(1);
    run_to_halt("pc wrap");
    idx = -1;
    for (int i = 0; i + 1 < fetch_q.size(); i++)
      if (fetch_q[i] == 8'hFF && idx < 0) idx = i;
    check("pc wrap ff seen", idx >= 0, 1);
    if (idx >= 0) check("pc wrap next", fetch_q[idx + 1], 8'h00);
    check_model("pc wrap");

    // Reset during EXECUTE discards everything
    fill_mem();
    mem[0] = 16'hB005; mem[1] = 16'hB406; mem[2] = 16'hB807;
    mem[3] = 16'hBC08;
    start_run(0);
    seen = 0; n = 0;
    while (seen < 2 && n < 100) begin
      @(posedge clk); #1;
      if (alu_enable) seen++;
      n++;
    end
    check("exec reached", seen, 2);
    #2 reset = 1'b1;
    #1;
    check("async reset",
          {alu_enable, out_valid, imem_req, imem_addr}, 0);
    fill_mem();
    mem[0] = 16'hC000; mem[1] = 16'hC400;
    mem[2] = 16'hC800; mem[3] = 16'hCC00;
    @(posedge clk); #1;
    clear_mon();
    reset = 1'b0;
    run_to_halt("post reset");
    check("post reset outs", out_q.size(), 4);
    n = 0;
    foreach (out_q[i]) if (out_q[i] != 0) n++;
    check("regs cleared", n, 0);

    // Random programs
    for (int t = 0; t < 25; t++) begin
      int len;
      logic [3:0] op;
      fill_mem();
      len = $urandom_range(4, 14);
      for (int i = 0; i < len; i++) begin
        op = ($urandom_range(0, 9) < 4) ? 4'hB : 4'($urandom_range(0, 12));
        mem[i] = {op, 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)};
      end
      mem[len] = 16'hC000 | 16'($urandom_range(0, 3) << 10);
      start_run($urandom_range(0, 2));
      run_to_halt("random");
      check_model($sformatf("random %0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Fetch/decode/execute controller that drives the 8-bit ALU's opcode, operand and enable inputs and consumes its 16-bit result. It fetches 16-bit instructions over a req/ack port, holds a 4×8 register file, sequences one instruction at a time through the ALU and writes results back. It also handles the opcodes the ALU only passes through: load-immediate, output, jump, branch and halt.

## Interface
- No parameters: register count 4, data width 8, PC width 8, instruction width 16.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  8  fetch address (PC).
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  16  instruction word, sampled when imem_req && imem_ack.
- alu_enable  out  1  ALU enable, high for the EXECUTE cycle only.
- alu_opcode  out  4  ALU opcode.
- alu_operand_1  out  8  ALU operand 1.
- alu_operand_2  out  8  ALU operand 2.
- alu_result  in  16  ALU output, sampled in WRITEBACK.
- out_data  out  8  value from the OUT instruction.
- out_valid  out  1  one-cycle strobe with out_data.
- zero_flag  out  1  set when the last ALU result low byte is 0.
- carry_flag  out  1  bit 8 of the last ADD/SUB/INC/DEC result.
- hi_byte  out  8  alu_result[15:8] of the last MUL.
- div_err  out  1  sticky divide-by-zero flag (only with the guard macro).
- halted  out  1  high in HALT.

## Operation

**Instruction fields**
- [15:12] opcode, matching the ALU encoding.
- [11:10] rd, [9:8] rs, [7:0] imm.

**States**
- FETCH → DECODE → EXECUTE → WRITEBACK → FETCH.
- HALT is terminal.

**FETCH**
- imem_req=1, imem_addr=pc.
- On ack: latch the instruction and go to DECODE.

**DECODE**
- Registers alu_opcode=opcode, alu_operand_1=R[rd], alu_operand_2=R[rs].
- LDI (1011): operand_1=imm, writes back R[rd]←imm.
- OUT (1100): out_data=R[rd], out_valid=1 for this cycle, no ALU, pc+1, → FETCH.
- JMP (1101): pc←imm, → FETCH.
- BRZ (1110): pc←imm if zero_flag, else pc+1, → FETCH.
- HLT (1111): → HALT.
- All other opcodes: → EXECUTE.

**EXECUTE**
- alu_enable=1 for exactly one cycle.

**WRITEBACK**
- R[rd]←alu_result[7:0] and zero_flag updated, except for AND/OR/XOR/NOT, MOV (0000) and LDI, which leave flags unchanged.
- carry_flag updated only for 0001/0010/0101/0110.
- hi_byte updated only for MUL.
- pc←pc+1, with 8-bit wrap: 0xFF→0x00.

**HALT**
- Outputs hold, imem_req=0.
- Exit only through reset.

**Boundary rules**
- rd==rs is legal; the operand is read before the write.
- imem_ack while imem_req=0 is ignored.

## Timing
- Reset values:
  - FETCH state, pc=0, all registers 0.
  - All flags 0, hi_byte 0, out_data 0, out_valid 0.
  - alu_enable 0, alu_opcode 0, operands 0, imem_req 0.
- imem_req rises in the first cycle after reset deassertion.
- The ALU is combinational. alu_result is sampled at the end of WRITEBACK, one cycle after the alu_enable cycle.
- Cycle counts, measured from the ack cycle:
  - ALU instruction: 4 cycles minimum (FETCH, DECODE, EXECUTE, WRITEBACK).
  - LDI: also 4 cycles, because it uses the ALU pass-through.
  - JMP/BRZ/OUT/HLT: 2 cycles.
- Reset mid-operation: all state is discarded immediately and asynchronously. alu_enable and out_valid drop the same instant.

## Configuration
- Macro: ALU_SEQ_DIV_GUARD_EN.
- Defined: DIV (0100) with R[rs]==0 skips the ALU (alu_enable stays 0 in EXECUTE), writes R[rd]←0xFF, sets sticky div_err and leaves zero_flag unchanged.
- Undefined: DIV always goes through the ALU and alu_result[7:0] is written as-is. div_err is tied 0.

## Structure
- Package cpu_pkg holds:
  - Opcode localparams OP_MOV…OP_HLT.
  - State enum and instruction field bit positions.
- Sub-module regfile4x8: 2 asynchronous read ports, 1 synchronous write port, asynchronous reset to 0.

## Test plan
- LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0 → out_data=0x08, out_valid one cycle, zero_flag=0, carry_flag=0.
- LDI R0,0xFF; INC R0 → R0=0x00, zero_flag=1, carry_flag=1; a following BRZ 0x20 makes the next imem_addr 0x20.
- LDI R2,0x10; LDI R3,0x20; MUL R2,R3 → R2=0x00, hi_byte=0x02.
- DIV R0,R1 with R1=0: with the macro, R0=0xFF, div_err=1, no alu_enable pulse; without it, alu_enable pulses once.
- imem_ack delayed 3 cycles → imem_req and imem_addr stay stable, and the instruction completes with the correct result.
- Reset asserted during EXECUTE → alu_enable=0 immediately, pc=0, registers 0. HLT → halted=1 and imem_req stays 0 for 20 cycles.
